// File: rtl/mas_stream_acc.sv
// mas_stream_acc: streaming modular add/subtract accumulator.
// Each accepted operand is folded into a running residue mod Q over two
// registered cycles (raw sum, then one conditional +/-Q correction). The
// final residue and comparator flags are presented when the last operand
// of a frame has been folded.
module mas_stream_acc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_data,
  input  logic [1:0]   in_op,
  input  logic         in_last,
  input  logic [W:0]   q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_tcmp,
  output logic         out_err
);

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_FIX, S_OUT} state_t;

  localparam logic signed [W:0] Q_MIN = 2;

  state_t                r_state;
  state_t                w_next;
  logic [W-1:0]          r_acc;
  logic signed [W:0]     r_q;
  logic signed [W:0]     r_din;
  logic [1:0]            r_op;
  logic                  r_last;
  logic                  r_first;
  logic                  r_err;
  logic signed [W+1:0]   r_sum;
  logic [1:0]            r_tcmp;

  logic signed [W:0]     w_q_sel;
  logic signed [W:0]     w_din_s;
  logic                  w_din_bad;
  logic signed [W+1:0]   w_acc_ext;
  logic signed [W+1:0]   w_din_ext;
  logic signed [W+1:0]   w_q_ext;
  logic signed [W+1:0]   w_sum;
  logic signed [W+1:0]   w_fix;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_OUT);

  // Range check against the modulus in force for this operand: the live q
  // input on the first operand (it is being captured now), else the stored one.
  assign w_q_sel   = r_first ? $signed(q) : r_q;
  assign w_din_s   = $signed(in_data);
  assign w_din_bad = w_din_s[W] || (w_din_s >= w_q_sel);

  // Residue is always non-negative, so it is zero-extended into the sum.
  assign w_acc_ext = $signed({2'b00, r_acc});
  assign w_din_ext = {r_din[W], r_din};
  assign w_q_ext   = {r_q[W], r_q};

  // Raw sum/difference/load for the SUM cycle.
  always_comb begin
    w_sum = w_din_ext;
    case (r_op)
      2'b00:   w_sum = w_acc_ext + w_din_ext;
      2'b11:   w_sum = w_acc_ext - w_din_ext;
      default: w_sum = w_din_ext;
    endcase
  end

  // Single correction step for the FIX cycle; tcmp==10 passes through.
  always_comb begin
    w_fix = r_sum;
    case (r_tcmp)
      2'b00:   w_fix = r_sum + w_q_ext;
      2'b11:   w_fix = r_sum - w_q_ext;
      default: w_fix = r_sum;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_SUM;
      S_SUM:  w_next = S_FIX;
      S_FIX:  w_next = r_last ? S_OUT : S_IDLE;
      S_OUT:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, sum/flags, correction, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_din    <= '0;
      r_op     <= '0;
      r_last   <= 1'b0;
      r_first  <= 1'b1;
      r_err    <= 1'b0;
      r_sum    <= '0;
      r_tcmp   <= '0;
      out_data <= '0;
      out_tcmp <= '0;
      out_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_din  <= w_din_s;
            r_op   <= in_op;
            r_last <= in_last;
            if (r_first) begin
              r_q   <= $signed(q);
              r_err <= ($signed(q) < Q_MIN) || w_din_bad;
            end else begin
              r_err <= r_err || w_din_bad;
            end
          end
        end
        S_SUM: begin
          r_sum  <= w_sum;
          r_tcmp <= {(w_sum >= w_q_ext), !w_sum[W+1]};
        end
        S_FIX: begin
          r_acc <= w_fix[W-1:0];
          if (r_last) begin
            out_data <= w_fix[W-1:0];
            out_tcmp <= r_tcmp;
            out_err  <= r_err;
          end else begin
            r_first <= 1'b0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_first <= 1'b1;
            r_acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mas_stream_acc.sv
// Directed bench for mas_stream_acc (W=4): operand table plus hand-written
// back-pressure and mid-frame reset sequences.
module tb_mas_stream_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic [1:0] in_op;
  logic       in_last;
  logic [4:0] q;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_tcmp;
  logic       out_err;

  int n_chk = 0;
  int n_err = 0;

  mas_stream_acc #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .q(q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tcmp(out_tcmp), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] q;
    logic [1:0] op;
    logic [4:0] d;
    logic       last;
    logic [3:0] e_data;
    logic [1:0] e_tcmp;
    logic       e_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one operand and wait (bounded) for it to be accepted.
  task automatic send_op(input logic [4:0] qq, input logic [1:0] op,
                         input logic [4:0] d, input logic last);
    int k;
    @(negedge clk);
    q = qq; in_op = op; in_data = d; in_last = last; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Handshake timing after an accept: busy for SUM and FIX, then ready/valid.
  task automatic post_op(input logic last);
    @(negedge clk);
    chk("ready_low_sum", in_ready, 0);
    @(negedge clk);
    chk("ready_low_fix", in_ready, 0);
    chk("valid_low_fix", out_valid, 0);
    @(negedge clk);
    if (last) begin
      chk("valid_at_t2", out_valid, 1);
      chk("ready_low_out", in_ready, 0);
    end else begin
      chk("ready_at_t2", in_ready, 1);
    end
  endtask

  task automatic take_result(input logic [3:0] ed, input logic [1:0] et, input logic ee);
    chk("out_data", out_data, ed);
    chk("out_tcmp", out_tcmp, et);
    chk("out_err", out_err, ee);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("valid_dropped", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    tbl[0]  = '{5'd13, 2'b00, 5'd7,  1'b0, 4'd0,  2'b00, 1'b0};
    tbl[1]  = '{5'd13, 2'b00, 5'd9,  1'b1, 4'd3,  2'b11, 1'b0};
    tbl[2]  = '{5'd13, 2'b00, 5'd2,  1'b0, 4'd0,  2'b00, 1'b0};
    tbl[3]  = '{5'd13, 2'b11, 5'd5,  1'b1, 4'd10, 2'b00, 1'b0};
    tbl[4]  = '{5'd13, 2'b00, 5'd4,  1'b0, 4'd0,  2'b00, 1'b0};
    tbl[5]  = '{5'd13, 2'b01, 5'd6,  1'b0, 4'd0,  2'b00, 1'b0};
    tbl[6]  = '{5'd13, 2'b00, 5'd5,  1'b1, 4'd11, 2'b01, 1'b0};
    tbl[7]  = '{5'd13, 2'b00, 5'd14, 1'b1, 4'd1,  2'b11, 1'b1};
    tbl[8]  = '{5'd1,  2'b00, 5'd0,  1'b1, 4'd0,  2'b01, 1'b1};
    tbl[9]  = '{5'd13, 2'b11, 5'd0,  1'b1, 4'd0,  2'b01, 1'b0};
    tbl[10] = '{5'd13, 2'b00, 5'd10, 1'b0, 4'd0,  2'b00, 1'b0};
    tbl[11] = '{5'd5,  2'b00, 5'd6,  1'b1, 4'd3,  2'b11, 1'b0};
    tbl[12] = '{5'd13, 2'b00, 5'd14, 1'b0, 4'd0,  2'b00, 1'b0};
    tbl[13] = '{5'd13, 2'b10, 5'd2,  1'b1, 4'd2,  2'b01, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_last = 1'b0;
    q = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tcmp", out_tcmp, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    for (int i = 0; i < 14; i++) begin
      send_op(tbl[i].q, tbl[i].op, tbl[i].d, tbl[i].last);
      post_op(tbl[i].last);
      if (tbl[i].last) take_result(tbl[i].e_data, tbl[i].e_tcmp, tbl[i].e_err);
    end

    // Back-pressure: result must hold while out_ready stays low.
    send_op(5'd7, 2'b00, 5'd5, 1'b0);
    post_op(1'b0);
    send_op(5'd7, 2'b00, 5'd4, 1'b1);
    post_op(1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 2);
      chk("bp_tcmp", out_tcmp, 2'b11);
      chk("bp_ready", in_ready, 0);
      @(negedge clk);
    end
    take_result(4'd2, 2'b11, 1'b0);
    // New frame must start from acc=0 and the freshly sampled q=15.
    send_op(5'd15, 2'b00, 5'd14, 1'b1);
    post_op(1'b1);
    take_result(4'd14, 2'b01, 1'b0);

    // Reset during FIX of the second operand: frame discarded.
    send_op(5'd13, 2'b00, 5'd5, 1'b0);
    post_op(1'b0);
    send_op(5'd13, 2'b00, 5'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_tcmp", out_tcmp, 0);
    chk("mrst_out_err", out_err, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_no_valid", out_valid, 0);
    end
    send_op(5'd13, 2'b00, 5'd3, 1'b1);
    post_op(1'b1);
    take_result(4'd3, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
